// File: rtl/cv_x_if_pkg.sv
// Shared x-interface types: result entry carried from the accelerator result
// channel into the core register file write port.
package cv_x_if_pkg;

  localparam int unsigned X_RD_W   = 5;
  localparam int unsigned X_DATA_W = 32;

  typedef struct packed {
    logic [X_RD_W-1:0]   rd;
    logic [X_DATA_W-1:0] data;
  } x_result_entry_t;

endpackage

// File: rtl/cv32e40p_x_result_fifo.sv
// Generic DEPTH-entry synchronous FIFO; pointers wrap naturally modulo DEPTH
// (DEPTH must be a power of two), count reaches DEPTH exactly when full.
module cv32e40p_x_result_fifo
  import cv_x_if_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = x_result_entry_t
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  entry_t                   wdata_i,
  input  logic                     pop_i,
  output entry_t                   head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  entry_t        mem_q [DEPTH];
  logic          do_push, do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rptr_q];

  // Overflow/underflow requests are ignored rather than corrupting state.
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cv32e40p_x_result_buf.sv
// Buffers accelerator results and retires them in order into the shared
// register file write port, yielding to core writeback with a starvation guard.
module cv32e40p_x_result_buf
  import cv_x_if_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned STARVE_MAX = 8,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   x_result_valid_i,
  output logic                   x_result_ready_o,
  input  logic [4:0]             x_result_rd_i,
  input  logic [31:0]            x_result_data_i,
  input  logic                   x_result_we_i,
  input  logic                   core_wb_we_i,
  output logic                   wb_hold_o,
  output logic                   rf_we_o,
  output logic [4:0]             rf_waddr_o,
  output logic [31:0]            rf_wdata_o,
  output logic                   x_rvalid_o,
  output logic [4:0]             x_rwaddr_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   empty_o
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  x_result_entry_t in_entry, head_entry, out_entry;
  logic            fifo_full, fifo_empty;
  logic            push_hs, bypass_hit, drain, fifo_push, fifo_pop;
  logic [SW-1:0]   starve_q, starve_d;
  logic            hold_q;

  assign in_entry = '{rd: x_result_rd_i, data: x_result_data_i};

  // Ready depends only on registered occupancy, never on core_wb_we_i.
  assign x_result_ready_o = ~fifo_full;
  assign push_hs          = x_result_valid_i & x_result_ready_o;
  assign bypass_hit       = BYPASS & fifo_empty & push_hs & x_result_we_i;
  assign drain            = ~core_wb_we_i & (~fifo_empty | bypass_hit);

  // A result written straight through on bypass never occupies a slot;
  // results without a register write are consumed and dropped.
  assign fifo_push = push_hs & x_result_we_i & ~(bypass_hit & drain);
  assign fifo_pop  = drain & ~fifo_empty;
  assign out_entry = fifo_empty ? in_entry : head_entry;

  cv32e40p_x_result_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (x_result_entry_t)
  ) i_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (fifo_push),
    .wdata_i (in_entry),
    .pop_i   (fifo_pop),
    .head_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (count_o)
  );

  assign empty_o = fifo_empty;

  // x0 retires (scoreboard clear) but is never written.
  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = '0;
    x_rvalid_o = 1'b0;
    x_rwaddr_o = '0;
    if (drain) begin
      rf_we_o    = (out_entry.rd != 5'd0);
      rf_waddr_o = out_entry.rd;
      rf_wdata_o = out_entry.data;
      x_rvalid_o = 1'b1;
      x_rwaddr_o = out_entry.rd;
    end
  end

  // Counts cycles a waiting entry is blocked by core writeback; saturates.
  always_comb begin
    starve_d = starve_q;
    if (drain || fifo_empty) begin
      starve_d = '0;
    end else if (core_wb_we_i && (starve_q != STARVE_LIM)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      starve_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      starve_q <= starve_d;
      hold_q   <= (starve_d == STARVE_LIM);
    end
  end

  assign wb_hold_o = hold_q;

`ifndef SYNTHESIS
  a_core_obeys_hold : assert property (@(posedge clk_i) disable iff (!rst_ni)
    wb_hold_o |-> !core_wb_we_i);
  a_count_bounded : assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_o <= ($clog2(DEPTH)+1)'(DEPTH));
`endif

endmodule

// File: doc/cv32e40p_x_result_buf.md
Name: cv32e40p_x_result_buf

Overview:
Buffers accelerator result transactions returning over the x-interface and retires them into the core register file's second write port.
Sits directly downstream of the x-interface dispatcher:
- consumes the accelerator result channel;
- produces the scoreboard-clear strobe (x_rvalid/x_rwaddr) that the dispatcher uses to release offloaded destination registers.
The core's own writeback always has priority on the shared port. A starvation counter guarantees forward progress.

Parameters:
DEPTH, 4, result FIFO entries; power of two, >= 2
STARVE_MAX, 8, consecutive blocked drain cycles before wb_hold_o is raised; >= 1
BYPASS, 1, 1 = an empty buffer may write an incoming result in the same cycle

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
x_result_valid_i  in  1  accelerator result valid
x_result_ready_o  out  1  buffer can accept a result
x_result_rd_i  in  5  destination register
x_result_data_i  in  32  result data
x_result_we_i  in  1  result carries a register write
core_wb_we_i  in  1  core WB stage uses the write port this cycle
wb_hold_o  out  1  request to core: suppress core_wb_we_i next cycle
rf_we_o  out  1  register file write enable
rf_waddr_o  out  5  register file write address
rf_wdata_o  out  32  register file write data
x_rvalid_o  out  1  result retired (scoreboard clear strobe to dispatcher)
x_rwaddr_o  out  5  register cleared by x_rvalid_o
count_o  out  clog2(DEPTH)+1  occupancy
empty_o  out  1  buffer empty

Behaviour:
- Reset:
  - Clock is clk_i; reset rst_ni is asynchronous, active-low.
  - FIFO pointers, count, starvation counter and wb_hold_o are cleared.
  - Resulting output values: x_result_ready_o=1, empty_o=1, count_o=0, rf_we_o=0, x_rvalid_o=0, rf_waddr_o=0, rf_wdata_o=0, x_rwaddr_o=0.
  - Reset mid-operation discards all entries with no retire pulse.
- Accept:
  - x_result_ready_o = ~full, a registered-state function only; it has no combinational dependency on core_wb_we_i.
  - A push occurs on valid & ready.
  - Results with x_result_we_i=0 are accepted and discarded: no entry, no pulse.
- Drain condition: drain = ~core_wb_we_i & (~empty | bypass_hit).
  - bypass_hit = BYPASS & empty & valid & ready & we.
- Drain action: rf_we_o=1 and x_rvalid_o=1, with addr/data taken from the FIFO head, or from the input on bypass_hit.
  - A bypassed result is not stored.
  - A popped entry frees its slot at the next clock edge.
- Ordering: strict in-order retirement. Duplicate rd values are allowed and retire in arrival order.
- rd = 0: x_rvalid_o pulses with x_rwaddr_o=0, but rf_we_o is forced to 0 (x0 is never written).
- Simultaneous push and pop:
  - When not full, the count is unchanged.
  - When full, ready is 0, so no push occurs even if a pop happens that cycle.
- Full: ready stays 0 until the cycle after a pop.
- Empty: when empty and not bypassing, all outputs idle.
- Starvation:
  - The counter increments each cycle that the buffer is non-empty and core_wb_we_i=1.
  - It clears on any drain or when the buffer is empty.
  - When counter == STARVE_MAX, wb_hold_o is registered high.
  - The core must hold core_wb_we_i=0 while wb_hold_o=1.
  - wb_hold_o clears the cycle after the drain it caused.
  - Counter width is clog2(STARVE_MAX+1); it saturates and never wraps.
- Pointers: clog2(DEPTH)-bit, wrapping naturally modulo DEPTH. count_o = DEPTH exactly when full.
- Latency:
  - Bypass: 0 cycles, input to write port.
  - Buffered: at least 1 cycle.

Decomposition:
- No new package types are required. Widths are derived locally via $clog2.
- The result entry struct {rd[4:0], data[31:0]} is placed in cv_x_if_pkg as x_result_entry_t, for reuse by the dispatcher testbench.
- One sub-module, cv32e40p_x_result_fifo: a generic DEPTH x entry synchronous FIFO with push/pop/full/empty/count.
  - It owns the pointer and wrap logic.
  - The top level owns the arbitration, bypass and starvation logic.

Test Plan:
- Bypass: empty buffer, core_wb_we_i=0, push rd=5 data=0xDEADBEEF -> same cycle rf_we_o=1, rf_waddr_o=5, x_rvalid_o=1, count_o remains 0.
- Core priority: core_wb_we_i=1, push rd=3 then rd=7 -> no rf_we_o, count_o=2. Drop core_wb_we_i -> rd=3 retires, then rd=7 on the next cycle, in order.
- Full: DEPTH=4, core_wb_we_i=1, push 5 results -> ready=0 after the 4th push, 5th held. Release core -> ready=1 the cycle after the first pop, 5th accepted.
- Starvation: STARVE_MAX=8, one entry, core_wb_we_i=1 continuously -> wb_hold_o=1 after 8 blocked cycles. Bench drops core_wb_we_i -> entry retires, wb_hold_o=0 the next cycle.
- Corner results:
  - push we=0 -> no pulse, count unchanged;
  - push rd=0 -> x_rvalid_o=1 with x_rwaddr_o=0, and rf_we_o=0.
- Reset mid-operation: 3 entries buffered, assert rst_ni low -> empty_o=1, count_o=0, no x_rvalid_o pulse after release.
